// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : if_pkg
//  Brief   : Shared types and constants for the instruction-fetch stage.
//  Revision: 1.0  initial release
// ============================================================================
package if_pkg;

    // Fetch FSM encoding.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t c_ST_FETCH = 2'd0;
    localparam fetch_state_t c_ST_DRAIN = 2'd1;
    localparam fetch_state_t c_ST_BUF   = 2'd2;
    localparam fetch_state_t c_ST_HALT  = 2'd3;

    // Opcodes the fetch stage cares about (instruction bits [15:12]).
    localparam logic [3:0]  c_OP_HLT    = 4'b1111;
    localparam logic [3:0]  c_OP_B      = 4'b1100;

    // Instruction placed in IF/ID when it holds nothing real.
    localparam logic [15:0] c_NOP_INSTR = 16'h0000;

    // Byte increment between consecutive instructions.
    localparam int          c_PC_INC    = 2;

    function automatic logic is_hlt(input logic [3:0] opcode);
        return (opcode == c_OP_HLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module  : if_skid_buf
//  Brief   : One-entry {instr, pc_plus} holding register with load, unload
//            and clear. Clear dominates load, load dominates unload.
//  Revision: 1.0  initial release
// ============================================================================
module if_skid_buf
    import if_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_load,
    input  wire logic               i_unload,
    input  wire logic               i_clear,
    input  wire logic [INSTR_W-1:0] i_instr,
    input  wire logic [PC_W-1:0]    i_pc_plus,
    output logic                    o_valid,
    output logic [INSTR_W-1:0]      o_instr,
    output logic [PC_W-1:0]         o_pc_plus
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_plus;

    // Capture a fetched instruction while downstream is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_instr   <= INSTR_W'(c_NOP_INSTR);
            r_pc_plus <= '0;
        end else if (i_clear) begin
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_instr   <= i_instr;
            r_pc_plus <= i_pc_plus;
        end else if (i_unload) begin
            r_valid   <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_instr   = r_instr;
    assign o_pc_plus = r_pc_plus;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module  : if_fetch_stage
//  Brief   : Instruction-fetch stage. Owns the PC, talks to a variable-latency
//            instruction memory over req/rdy, redirects on taken branches,
//            absorbs stalls in a one-entry skid buffer and stops on HLT.
//  Revision: 1.0  initial release
// ============================================================================
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter int              PC_INC   = c_PC_INC,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               br_ctrl,
    input  wire logic [PC_W-1:0]    br_target,
    input  wire logic               stall,
    output logic                    imem_req,
    output logic [PC_W-1:0]         imem_addr,
    input  wire logic               imem_rdy,
    input  wire logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0]      if_id_instr,
    output logic [PC_W-1:0]         if_id_pc_plus,
    output logic                    if_id_valid,
    output logic                    halted
);

    localparam logic [PC_W-1:0] c_PC_STEP = PC_W'(PC_INC);

    fetch_state_t       r_state,     w_state_nxt;
    logic [PC_W-1:0]    r_pc,        w_pc_nxt;
    logic [PC_W-1:0]    r_pend_pc,   w_pend_pc_nxt;
    logic               r_req,       w_req_nxt;
    logic [INSTR_W-1:0] r_if_instr,  w_if_instr_nxt;
    logic [PC_W-1:0]    r_if_pcp,    w_if_pcp_nxt;
    logic               r_if_valid,  w_if_valid_nxt;

    logic               w_skid_load, w_skid_unload, w_skid_clear;
    logic               w_skid_valid;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [PC_W-1:0]    w_skid_pcp;
    logic [PC_W-1:0]    w_pc_plus;

    // PC arithmetic wraps naturally at 2^PC_W.
    assign w_pc_plus = r_pc + c_PC_STEP;

    if_skid_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_skid_load),
        .i_unload  (w_skid_unload),
        .i_clear   (w_skid_clear),
        .i_instr   (imem_data),
        .i_pc_plus (w_pc_plus),
        .o_valid   (w_skid_valid),
        .o_instr   (w_skid_instr),
        .o_pc_plus (w_skid_pcp)
    );

    // Next-state: branch redirect beats stall, stall beats normal fetch.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_pc_nxt  = r_pend_pc;
        w_req_nxt      = r_req;
        w_if_instr_nxt = r_if_instr;
        w_if_pcp_nxt   = r_if_pcp;
        w_if_valid_nxt = r_if_valid;
        w_skid_load    = 1'b0;
        w_skid_unload  = 1'b0;
        w_skid_clear   = 1'b0;

        if (br_ctrl) begin
            w_if_valid_nxt = 1'b0;
            w_skid_clear   = 1'b1;
            if (r_req && !imem_rdy) begin
                // Request still in flight: it must complete before redirecting.
                w_pend_pc_nxt = br_target;
                w_state_nxt   = c_ST_DRAIN;
            end else begin
                w_pc_nxt      = br_target;
                w_state_nxt   = c_ST_FETCH;
                w_req_nxt     = !stall;
            end
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (r_req) begin
                        if (imem_rdy) begin
                            w_pc_nxt = w_pc_plus;
                            if (stall) begin
                                w_skid_load = 1'b1;
                                w_req_nxt   = 1'b0;
                                w_state_nxt = c_ST_BUF;
                            end else begin
                                w_if_instr_nxt = imem_data;
                                w_if_pcp_nxt   = w_pc_plus;
                                w_if_valid_nxt = 1'b1;
                                if (is_hlt(imem_data[INSTR_W-1 -: 4])) begin
                                    w_req_nxt   = 1'b0;
                                    w_state_nxt = c_ST_HALT;
                                end else begin
                                    w_req_nxt   = 1'b1;
                                end
                            end
                        end else if (!stall) begin
                            w_if_valid_nxt = 1'b0;
                        end
                    end else if (!stall) begin
                        w_req_nxt      = 1'b1;
                        w_if_valid_nxt = 1'b0;
                    end
                end
                c_ST_BUF: begin
                    if (!stall) begin
                        w_if_instr_nxt = w_skid_instr;
                        w_if_pcp_nxt   = w_skid_pcp;
                        w_if_valid_nxt = w_skid_valid;
                        w_skid_unload  = 1'b1;
                        if (w_skid_valid && is_hlt(w_skid_instr[INSTR_W-1 -: 4])) begin
                            w_state_nxt = c_ST_HALT;
                        end else begin
                            w_req_nxt   = 1'b1;
                            w_state_nxt = c_ST_FETCH;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    // Data returned here belongs to the wrong path and is dropped.
                    if (imem_rdy) begin
                        w_pc_nxt    = r_pend_pc;
                        w_req_nxt   = !stall;
                        w_state_nxt = c_ST_FETCH;
                    end
                end
                c_ST_HALT: begin
                    w_req_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = c_ST_FETCH;
                    w_req_nxt   = 1'b0;
                end
            endcase
        end
    end

    // State, PC, request and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_FETCH;
            r_pc       <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_req      <= 1'b0;
            r_if_instr <= INSTR_W'(c_NOP_INSTR);
            r_if_pcp   <= '0;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_req      <= w_req_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pcp   <= w_if_pcp_nxt;
            r_if_valid <= w_if_valid_nxt;
        end
    end

    assign imem_req      = r_req;
    assign imem_addr     = r_pc;
    assign if_id_instr   = r_if_instr;
    assign if_id_pc_plus = r_if_pcp;
    assign if_id_valid   = r_if_valid;
    assign halted        = (r_state == c_ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_if_fetch_stage
//  Brief   : Directed self-checking bench for if_fetch_stage. Accepted fetches
//            are pushed to a scoreboard and popped when IF/ID loads.
//  Revision: 1.0  initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_ctrl = 1'b0;
    logic [15:0] br_target = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = '0;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus;
    logic        if_id_valid;
    logic        halted;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .br_ctrl       (br_ctrl),
        .br_target     (br_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdy      (imem_rdy),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus (if_id_pc_plus),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Instruction image: opcode 2 with the low address bits as payload.
    function automatic logic [15:0] mem(input logic [15:0] a);
        return {4'h2, a[11:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1ns later.
    task automatic cyc(input logic rdy, input logic [15:0] data, input logic stl,
                       input logic br, input logic [15:0] tgt);
        imem_rdy  = rdy;
        imem_data = data;
        stall     = stl;
        br_ctrl   = br;
        br_target = tgt;
        @(posedge clk);
        #1;
        imem_rdy  = 1'b0;
        br_ctrl   = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
        chk({tag, "_sb_nonempty"}, {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_instr"}, {16'd0, if_id_instr}, {16'd0, e[31:16]});
            chk({tag, "_pc_plus"}, {16'd0, if_id_pc_plus}, {16'd0, e[15:0]});
        end
    endtask

    // Zero-wait fetch at the expected address, result checked next cycle.
    task automatic fetch(input string tag, input logic [15:0] a);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, {16'd0, imem_addr}, {16'd0, a});
        sb_q.push_back({mem(a), a + 16'd2});
        cyc(1'b1, mem(a), 1'b0, 1'b0, 16'h0);
        pop_chk(tag);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"}, {16'd0, imem_addr}, 32'd0);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_instr"}, {16'd0, if_id_instr}, 32'd0);
        chk({tag, "_pc_plus"}, {16'd0, if_id_pc_plus}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        // First request after reset
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("start_valid", {31'd0, if_id_valid}, 32'd0);

        // Back-to-back zero-wait fetches 0,2,4,6
        for (int i = 0; i < 4; i++) fetch("seq", 16'(2 * i));

        // Three-cycle latency at address 8: two bubbles, addr held
        for (int i = 0; i < 2; i++) begin
            chk("lat_req", {31'd0, imem_req}, 32'd1);
            chk("lat_addr", {16'd0, imem_addr}, 32'h8);
            cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
            chk("lat_bubble", {31'd0, if_id_valid}, 32'd0);
        end
        fetch("lat", 16'h8);

        // Stall coincident with rdy at 10 -> skid buffer, IF/ID holds data@8
        chk("stl_addr", {16'd0, imem_addr}, 32'hA);
        sb_q.push_back({mem(16'hA), 16'hC});
        cyc(1'b1, mem(16'hA), 1'b1, 1'b0, 16'h0);
        chk("stl_req", {31'd0, imem_req}, 32'd0);
        chk("stl_hold_instr", {16'd0, if_id_instr}, {16'd0, mem(16'h8)});
        chk("stl_hold_pcp", {16'd0, if_id_pc_plus}, 32'hA);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        chk("stl_hold_req", {31'd0, imem_req}, 32'd0);
        chk("stl_hold_valid", {31'd0, if_id_valid}, 32'd1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        pop_chk("unstall");
        chk("unstall_req", {31'd0, imem_req}, 32'd1);
        chk("unstall_addr", {16'd0, imem_addr}, 32'hC);

        // Branch while request at 12 is outstanding -> DRAIN, data dropped
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0040);
        chk("drain_valid", {31'd0, if_id_valid}, 32'd0);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_addr", {16'd0, imem_addr}, 32'hC);
        cyc(1'b1, mem(16'hC), 1'b0, 1'b0, 16'h0);
        chk("drain_discard", {31'd0, if_id_valid}, 32'd0);
        chk("redir_req", {31'd0, imem_req}, 32'd1);
        chk("redir_addr", {16'd0, imem_addr}, 32'h40);

        // Branch in the same cycle as rdy: redirect at once, data dropped
        cyc(1'b1, mem(16'h40), 1'b0, 1'b1, 16'h0080);
        chk("brrdy_valid", {31'd0, if_id_valid}, 32'd0);
        chk("brrdy_addr", {16'd0, imem_addr}, 32'h80);

        // HLT fetched at 0x80 -> halted, no requests
        sb_q.push_back({16'hF123, 16'h0082});
        cyc(1'b1, 16'hF123, 1'b0, 1'b0, 16'h0);
        pop_chk("hlt");
        for (int i = 0; i < 3; i++) begin
            chk("hlt_halted", {31'd0, halted}, 32'd1);
            chk("hlt_req", {31'd0, imem_req}, 32'd0);
            cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        end
        chk("hlt_hold_valid", {31'd0, if_id_valid}, 32'd1);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0010);
        chk("unhalt_halted", {31'd0, halted}, 32'd0);
        chk("unhalt_valid", {31'd0, if_id_valid}, 32'd0);
        chk("unhalt_req", {31'd0, imem_req}, 32'd1);
        chk("unhalt_addr", {16'd0, imem_addr}, 32'h10);

        // PC wrap: redirect to FFFE, fetch, next address wraps to 0
        cyc(1'b1, mem(16'h10), 1'b0, 1'b1, 16'hFFFE);
        fetch("wrap", 16'hFFFE);
        chk("wrap_next_addr", {16'd0, imem_addr}, 32'h0);

        // Branch while in BUF clears the skid entry
        cyc(1'b1, mem(16'h0), 1'b1, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020);
        chk("bufbr_valid", {31'd0, if_id_valid}, 32'd0);
        chk("bufbr_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("bufbr_noskid", {31'd0, if_id_valid}, 32'd0);
        chk("bufbr_req2", {31'd0, imem_req}, 32'd1);
        chk("bufbr_addr", {16'd0, imem_addr}, 32'h20);

        // Async reset mid-request takes effect without a clock edge
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("prerst_req", {31'd0, imem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_reset("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("postrst_req", {31'd0, imem_req}, 32'd1);
        chk("postrst_addr", {16'd0, imem_addr}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage feeding the IF/ID pipeline register.
- Owns the PC and issues requests to a variable-latency instruction memory over a req/rdy handshake.
- Redirects the PC on the branch-taken signal (br_ctrl, br_target) fed back from the branch-resolution stage.
- Handles downstream stalls with a one-entry skid buffer, flushes on taken branches, and stops fetching on HLT.

Parameters:
- PC_W, 16, PC and address width
- INSTR_W, 16, instruction width
- PC_INC, 2, byte increment per instruction
- RESET_PC, 16'h0000, PC after reset

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- br_ctrl  in  1  taken-branch redirect, from branch control
- br_target  in  PC_W  redirect target, valid when br_ctrl=1
- stall  in  1  hazard unit: hold IF/ID and PC
- imem_req  out  1  memory request
- imem_addr  out  PC_W  request address
- imem_rdy  in  1  memory data valid this cycle (completes request)
- imem_data  in  INSTR_W  fetched instruction
- if_id_instr  out  INSTR_W  IF/ID instruction
- if_id_pc_plus  out  PC_W  IF/ID PC+PC_INC
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch stopped on HLT

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=FETCH, imem_req=0.
  - if_id_instr=NOP_INSTR, if_id_pc_plus=0, if_id_valid=0, halted=0, skid buffer empty.
- States: FETCH, DRAIN, BUF, HALT. Priority every cycle: rst > br_ctrl > stall > normal.
- Handshake:
  - imem_req is registered. Once asserted, req and addr stay stable until the cycle imem_rdy=1; no request is ever abandoned.
  - imem_rdy may arrive in the cycle after req rises, or any number of cycles later.
  - At most one outstanding request.
- FETCH, normal path:
  - imem_addr=pc; imem_req=1 unless a new request would start while stall=1.
  - On rdy with stall=0: if_id_instr<=imem_data, if_id_pc_plus<=pc+PC_INC, if_id_valid<=1, pc<=pc+PC_INC, new request issued next cycle. Throughput is one instruction per cycle with single-cycle memory.
  - On rdy with stall=1: data and pc+PC_INC go into the skid buffer, pc advances, go to BUF.
  - No rdy and stall=0: if_id_valid<=0 (bubble).
- BUF:
  - imem_req=0; IF/ID holds.
  - When stall drops, the skid contents load into IF/ID (valid=1) and state returns to FETCH.
- br_ctrl=1 (overrides stall):
  - if_id_valid<=0 and the skid buffer is cleared.
  - No request outstanding, or rdy this cycle: pc<=br_target, go to FETCH, returned data discarded.
  - Request outstanding without rdy: latch br_target as the pending PC and go to DRAIN.
- DRAIN:
  - Hold req until rdy, discard the data, pc<=pending PC, go to FETCH.
  - A further br_ctrl in DRAIN overwrites the pending PC; latest wins.
- HLT:
  - When an instruction with opcode [15:12]=OP_HLT loads into IF/ID, enter HALT next cycle.
  - HALT: imem_req=0, halted=1, IF/ID holds.
  - br_ctrl in HALT flushes, sets pc<=br_target and returns to FETCH. This covers an HLT fetched in a branch shadow.
- Arithmetic: pc+PC_INC is modulo 2^PC_W, so 16'hFFFE wraps to 16'h0000.
- Reset mid-transaction aborts immediately. The memory must tolerate req dropping under rst.

Decomposition:
- Shared package if_pkg holds:
  - fetch_state_t enum (FETCH, DRAIN, BUF, HALT)
  - OP_HLT=4'b1111, OP_B=4'b1100
  - NOP_INSTR
  - PC_INC
- Sub-module if_skid_buf: one-entry {instr, pc_plus} holding register with load, unload and clear.

Test Plan:
- Zero-wait memory, no stall, 4 sequential fetches from reset -> imem_addr 0,2,4,6 on consecutive cycles; IF/ID gets pc_plus 2,4,6,8 with valid=1 each cycle.
- Memory with 3-cycle rdy latency -> req/addr stable 3 cycles, if_id_valid=0 for 2 bubbles, then 1 with the correct data.
- stall=1 asserted in the same cycle as rdy at pc=4 -> BUF; IF/ID unchanged; on stall release IF/ID gets data@4 with pc_plus=6; next req at addr 6.
- br_ctrl=1, br_target=16'h0040 while a 2-cycle request at 8 is outstanding -> DRAIN, data@8 discarded, if_id_valid=0, next req at 16'h0040.
- HLT loaded into IF/ID -> halted=1, imem_req=0 indefinitely; then br_ctrl with target 16'h0010 -> halted=0, req at 16'h0010.
- pc=16'hFFFE fetch -> pc_plus=16'h0000, next req at 16'h0000; async rst asserted mid-request -> all outputs at reset values immediately.
